// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem (up- and down-counting timers).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/timer_irq_latch.sv
// Sticky interrupt flag: an enabled set beats a simultaneous clear.
module timer_irq_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic en,
  input  logic clr,
  output logic flag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (set && en) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/time_down.sv
// One-shot / periodic count-down timer with expiry pulse and sticky irq.
module time_down
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] cfg_load,
  input  logic             irq_en,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             expire,
  output logic             irq
);

  state_t state;
  logic   load_ok;
  logic   terminal;

  // A zero-interval trig is treated as absent, so stop/count still apply.
  always_comb begin
    load_ok  = trig && (cfg_load != '0);
    terminal = !load_ok && !stop && (state != IDLE) && !pause &&
               (cnt == CNT_W'(1));
  end

  // Resuming from PAUSED counts on the same edge, so each paused cycle
  // delays expiry by exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= terminal;
      if (load_ok) begin
        cnt   <= cfg_load;
        state <= pause ? PAUSED : RUN;
        busy  <= 1'b1;
      end else if (stop) begin
        cnt   <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state != IDLE) begin
        if (pause) begin
          state <= PAUSED;
        end else if (terminal) begin
          if ((mode == MODE_PERIODIC) && (cfg_load != '0)) begin
            cnt   <= cfg_load;
            state <= RUN;
          end else begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          cnt   <= cnt - CNT_W'(1);
          state <= RUN;
        end
      end
    end
  end

  timer_irq_latch u_irq (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (terminal),
    .en    (irq_en),
    .clr   (irq_clr),
    .flag  (irq)
  );

endmodule
